// File: rtl/sram_lsu_pkg.sv
// Shared types and constants for the SRAM load/store master.
package sram_lsu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE,
    ERR
  } lsu_state_t;

  // RV32I funct3 size/sign codes; load and store encodings overlap by design.
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // Highest byte offset inside the 512 KiB SRAM window.
  localparam logic [18:0] WINDOW_MAX = 19'h7FFFF;

endpackage

// File: rtl/lsu_data_align.sv
// Byte-lane placement for stores, lane extraction for loads, and the
// size/alignment legality check. Purely combinational.
module lsu_data_align
  import sram_lsu_pkg::*;
(
  input  logic        i_is_store,
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_wdata,
  output logic        o_access_ok,
  output logic [3:0]  o_bmask,
  output logic [31:0] o_wdata,
  input  logic [2:0]  i_ld_funct3,
  input  logic [1:0]  i_ld_off,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Store lane mapping and legality of the requested size at this offset.
  always_comb begin
    o_access_ok = 1'b0;
    o_bmask     = 4'b1111;
    o_wdata     = i_wdata;
    if (i_is_store) begin
      case (i_funct3)
        F3_SB: begin
          o_access_ok = 1'b1;
          o_bmask     = 4'b0001 << i_off;
          o_wdata     = {4{i_wdata[7:0]}};
        end
        F3_SH: begin
          o_access_ok = ~i_off[0];
          o_bmask     = i_off[1] ? 4'b1100 : 4'b0011;
          o_wdata     = {2{i_wdata[15:0]}};
        end
        F3_SW:   o_access_ok = (i_off == 2'b00);
        default: o_access_ok = 1'b0;
      endcase
    end else begin
      case (i_funct3)
        F3_LB, F3_LBU: o_access_ok = 1'b1;
        F3_LH, F3_LHU: o_access_ok = ~i_off[0];
        F3_LW:         o_access_ok = (i_off == 2'b00);
        default:       o_access_ok = 1'b0;
      endcase
    end
  end

  // Load lane extraction with sign or zero extension.
  always_comb begin
    ld_byte = i_rdata[7:0];
    case (i_ld_off)
      2'd1:    ld_byte = i_rdata[15:8];
      2'd2:    ld_byte = i_rdata[23:16];
      2'd3:    ld_byte = i_rdata[31:24];
      default: ld_byte = i_rdata[7:0];
    endcase
    ld_half = i_ld_off[1] ? i_rdata[31:16] : i_rdata[15:0];
    case (i_ld_funct3)
      F3_LB:   o_ld_data = {{24{ld_byte[7]}}, ld_byte};
      F3_LBU:  o_ld_data = {24'h0, ld_byte};
      F3_LH:   o_ld_data = {{16{ld_half[15]}}, ld_half};
      F3_LHU:  o_ld_data = {16'h0, ld_half};
      default: o_ld_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/sram_lsu_master.sv
// Load/store master bridging the core LSU port to a single-request SRAM
// controller, with request validation and a bounded wait for the ack.
//
// state | meaning
// IDLE  | accept a new core request
// ISSUE | one-cycle SRAM request pulse
// WAIT  | waiting for controller ack, bounded by the timeout counter
// DONE  | one-cycle completion pulse
// ERR   | one-cycle completion + error pulse, no SRAM access made
module sram_lsu_master
  import sram_lsu_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter int          TIMEOUT_CYCLES = 16
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_lsu_addr,
  input  logic [31:0] i_lsu_wdata,
  input  logic        i_lsu_wren,
  input  logic        i_lsu_rden,
  input  logic [2:0]  i_lsu_funct3,
  output logic [31:0] o_lsu_rdata,
  output logic        o_lsu_stall,
  output logic        o_lsu_done,
  output logic        o_lsu_err,
  output logic [17:0] o_sram_addr,
  output logic [31:0] o_sram_wdata,
  output logic [3:0]  o_sram_bmask,
  output logic        o_sram_wren,
  output logic        o_sram_rden,
  input  logic [31:0] i_sram_rdata,
  input  logic        i_sram_ack
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  lsu_state_t  state;
  logic [CW-1:0] wait_left;
  logic        is_load_q;
  logic [2:0]  ld_funct3_q;
  logic [1:0]  ld_off_q;

  logic [31:0] win_off;
  logic        in_win;
  logic        access_ok;
  logic        req_legal;
  logic [3:0]  al_bmask;
  logic [31:0] al_wdata;
  logic [31:0] ld_data;

  assign win_off   = i_lsu_addr - BASE_ADDR;
  assign in_win    = (win_off <= {13'd0, WINDOW_MAX});
  assign req_legal = (i_lsu_wren ^ i_lsu_rden) & access_ok & in_win;

  // Stall is held low while in reset so every output reads 0 during reset.
  assign o_lsu_stall = ~i_reset &
                       ((state == IDLE) ? req_legal : ((state == ISSUE) | (state == WAIT)));

  lsu_data_align u_align (
    .i_is_store  (i_lsu_wren),
    .i_funct3    (i_lsu_funct3),
    .i_off       (i_lsu_addr[1:0]),
    .i_wdata     (i_lsu_wdata),
    .o_access_ok (access_ok),
    .o_bmask     (al_bmask),
    .o_wdata     (al_wdata),
    .i_ld_funct3 (ld_funct3_q),
    .i_ld_off    (ld_off_q),
    .i_rdata     (i_sram_rdata),
    .o_ld_data   (ld_data)
  );

  // Transaction FSM; wait_left counts down the remaining WAIT cycles.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state        <= IDLE;
      wait_left    <= '0;
      is_load_q    <= 1'b0;
      ld_funct3_q  <= 3'b000;
      ld_off_q     <= 2'b00;
      o_lsu_rdata  <= '0;
      o_lsu_done   <= 1'b0;
      o_lsu_err    <= 1'b0;
      o_sram_addr  <= '0;
      o_sram_wdata <= '0;
      o_sram_bmask <= '0;
      o_sram_wren  <= 1'b0;
      o_sram_rden  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_legal) begin
            state        <= ISSUE;
            o_sram_addr  <= {win_off[18:2], 1'b0};
            o_sram_wdata <= al_wdata;
            o_sram_bmask <= al_bmask;
            o_sram_wren  <= i_lsu_wren;
            o_sram_rden  <= i_lsu_rden;
            is_load_q    <= i_lsu_rden;
            ld_funct3_q  <= i_lsu_funct3;
            ld_off_q     <= i_lsu_addr[1:0];
          end else if (i_lsu_wren | i_lsu_rden) begin
            state      <= ERR;
            o_lsu_done <= 1'b1;
            o_lsu_err  <= 1'b1;
          end
        end
        ISSUE: begin
          state       <= WAIT;
          o_sram_wren <= 1'b0;
          o_sram_rden <= 1'b0;
          wait_left   <= CW'(TIMEOUT_CYCLES - 1);
        end
        WAIT: begin
          // An ack on the last allowed cycle still completes normally.
          if (i_sram_ack) begin
            state      <= DONE;
            o_lsu_done <= 1'b1;
            if (is_load_q) o_lsu_rdata <= ld_data;
          end else if (wait_left == '0) begin
            state      <= ERR;
            o_lsu_done <= 1'b1;
            o_lsu_err  <= 1'b1;
          end else begin
            wait_left <= wait_left - CW'(1);
          end
        end
        DONE, ERR: begin
          state      <= IDLE;
          o_lsu_done <= 1'b0;
          o_lsu_err  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_lsu_master.sv
// Directed bench for sram_lsu_master: a transaction-level model predicts
// every cycle's outputs, a stub SRAM responder acks after a set delay.
module tb_sram_lsu_master;

  localparam int          TO   = 16;
  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam logic [2:0]  LB = 3'd0, LH = 3'd1, LW = 3'd2, LBU = 3'd4, LHU = 3'd5;
  localparam logic [2:0]  SB = 3'd0, SH = 3'd1, SW = 3'd2;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b1;
  logic [31:0] i_lsu_addr = '0, i_lsu_wdata = '0;
  logic        i_lsu_wren = 1'b0, i_lsu_rden = 1'b0;
  logic [2:0]  i_lsu_funct3 = '0;
  logic [31:0] o_lsu_rdata;
  logic        o_lsu_stall, o_lsu_done, o_lsu_err;
  logic [17:0] o_sram_addr;
  logic [31:0] o_sram_wdata;
  logic [3:0]  o_sram_bmask;
  logic        o_sram_wren, o_sram_rden;
  logic [31:0] i_sram_rdata = '0;
  logic        i_sram_ack = 1'b0;

  sram_lsu_master #(.BASE_ADDR(BASE), .TIMEOUT_CYCLES(TO)) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_lsu_addr(i_lsu_addr), .i_lsu_wdata(i_lsu_wdata),
    .i_lsu_wren(i_lsu_wren), .i_lsu_rden(i_lsu_rden), .i_lsu_funct3(i_lsu_funct3),
    .o_lsu_rdata(o_lsu_rdata), .o_lsu_stall(o_lsu_stall),
    .o_lsu_done(o_lsu_done), .o_lsu_err(o_lsu_err),
    .o_sram_addr(o_sram_addr), .o_sram_wdata(o_sram_wdata), .o_sram_bmask(o_sram_bmask),
    .o_sram_wren(o_sram_wren), .o_sram_rden(o_sram_rden),
    .i_sram_rdata(i_sram_rdata), .i_sram_ack(i_sram_ack)
  );

  always #5 i_clk = ~i_clk;

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // ---------------- expectations, compared every cycle ----------------
  logic        chk_en = 1'b0;
  logic        exp_stall = 0, exp_wren = 0, exp_rden = 0, exp_done = 0, exp_err = 0;
  logic        exp_bus = 0, exp_wd_chk = 0;
  logic [17:0] exp_addr = '0;
  logic [3:0]  exp_bm = '0;
  logic [31:0] exp_wd = '0, exp_rdata = '0;
  int          stall_cnt = 0, wr_pulses = 0, rd_pulses = 0;

  always @(negedge i_clk) begin
    if (chk_en) begin
      chk("stall", 32'(o_lsu_stall), 32'(exp_stall));
      chk("sram_wren", 32'(o_sram_wren), 32'(exp_wren));
      chk("sram_rden", 32'(o_sram_rden), 32'(exp_rden));
      chk("lsu_done", 32'(o_lsu_done), 32'(exp_done));
      chk("lsu_err", 32'(o_lsu_err), 32'(exp_err));
      chk("lsu_rdata", o_lsu_rdata, exp_rdata);
      if (exp_bus) begin
        chk("sram_addr", 32'(o_sram_addr), 32'(exp_addr));
        chk("sram_bmask", 32'(o_sram_bmask), 32'(exp_bm));
        if (exp_wd_chk) chk("sram_wdata", o_sram_wdata, exp_wd);
      end
      if (o_lsu_stall) stall_cnt++;
      if (o_sram_wren) wr_pulses++;
      if (o_sram_rden) rd_pulses++;
    end
  end

  // ---------------- stub SRAM responder ----------------
  logic [31:0] rsp_mem [0:63];
  int          ack_dly = 0;
  int          rsp_cnt = 0;
  logic        rsp_pend = 1'b0, rsp_wr = 1'b0;
  logic [5:0]  rsp_idx = '0;
  logic [3:0]  rsp_bm = '0;
  logic [31:0] rsp_wd = '0;
  logic [17:0] cap_addr = '0;
  logic [3:0]  cap_bm = '0;
  logic [31:0] cap_wd = '0;

  always @(negedge i_clk) begin
    i_sram_ack = 1'b0;
    if (i_reset) begin
      rsp_pend = 1'b0;
    end else if (rsp_pend) begin
      rsp_cnt--;
      if (rsp_cnt == 0) begin
        i_sram_ack   = 1'b1;
        i_sram_rdata = rsp_mem[rsp_idx];
        if (rsp_wr)
          for (int b = 0; b < 4; b++)
            if (rsp_bm[b]) rsp_mem[rsp_idx][8*b +: 8] = rsp_wd[8*b +: 8];
        rsp_pend = 1'b0;
      end
    end else if ((o_sram_wren || o_sram_rden) && ack_dly > 0) begin
      rsp_pend = 1'b1;
      rsp_cnt  = ack_dly;
      rsp_wr   = o_sram_wren;
      rsp_idx  = o_sram_addr[6:1];
      rsp_bm   = o_sram_bmask;
      rsp_wd   = o_sram_wdata;
    end
    if (o_sram_wren) begin
      cap_addr = o_sram_addr;
      cap_bm   = o_sram_bmask;
      cap_wd   = o_sram_wdata;
    end
  end

  // ---------------- byte-addressed reference memory ----------------
  logic [7:0] mdl_mem [0:255];

  function automatic int acc_size(input logic wr, input logic [2:0] f3);
    if (!wr) begin
      case (f3)
        3'd0, 3'd4: return 1;
        3'd1, 3'd5: return 2;
        3'd2:       return 4;
        default:    return 0;
      endcase
    end
    case (f3)
      3'd0:    return 1;
      3'd1:    return 2;
      3'd2:    return 4;
      default: return 0;
    endcase
  endfunction

  function automatic logic is_legal(input logic wr, input logic rd, input logic [2:0] f3,
                                    input logic [31:0] a);
    logic [31:0] wo;
    int sz;
    wo = a - BASE;
    sz = acc_size(wr, f3);
    if (wr == rd) return 1'b0;
    if (wo > 32'h0007_FFFF) return 1'b0;
    if (sz == 0) return 1'b0;
    return (int'(a[1:0]) % sz) == 0;
  endfunction

  function automatic logic [31:0] ld_val(input logic [2:0] f3, input logic [31:0] a);
    int o;
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] w;
    o = int'(a[7:0]);
    b = mdl_mem[o];
    h = {mdl_mem[(o + 1) % 256], mdl_mem[o]};
    w = {mdl_mem[(o + 3) % 256], mdl_mem[(o + 2) % 256], mdl_mem[(o + 1) % 256], mdl_mem[o]};
    case (f3)
      3'd0:    return {{24{b[7]}}, b};
      3'd4:    return {24'h0, b};
      3'd1:    return {{16{h[15]}}, h};
      3'd5:    return {16'h0, h};
      default: return w;
    endcase
  endfunction

  task automatic set_exp(input logic st, input logic wr, input logic rd,
                         input logic dn, input logic er, input logic bus);
    exp_stall = st; exp_wren = wr; exp_rden = rd;
    exp_done = dn; exp_err = er; exp_bus = bus;
  endtask

  // One core request held until completion; dly = ack delay after the
  // request pulse in cycles (0 = responder never acks).
  task automatic xact(input logic wr, input logic rd, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] wd, input int dly);
    logic lg, tmo;
    int   n, sz;
    logic [31:0] wo;
    lg = is_legal(wr, rd, f3, a);
    sz = acc_size(wr, f3);
    wo = a - BASE;
    exp_addr = 18'((wo >> 2) << 1);
    exp_bm = 4'b1111;
    exp_wd = '0;
    if (lg && wr) begin
      exp_bm = '0;
      for (int i = 0; i < sz; i++) exp_bm[(int'(a[1:0]) + i) % 4] = 1'b1;
      for (int l = 0; l < 4; l++) exp_wd[8*l +: 8] = wd[8*(l % sz) +: 8];
    end
    exp_wd_chk = lg && wr;
    tmo = !(dly >= 1 && dly <= TO);
    n = tmo ? TO : dly;
    ack_dly = dly;
    stall_cnt = 0; wr_pulses = 0; rd_pulses = 0;
    i_lsu_wren = wr; i_lsu_rden = rd; i_lsu_funct3 = f3;
    i_lsu_addr = a; i_lsu_wdata = wd;
    set_exp(lg, 0, 0, 0, 0, 0);
    step();
    if (!lg) begin
      set_exp(0, 0, 0, 1, 1, 0);
      step();
    end else begin
      set_exp(1, wr, rd, 0, 0, 1);
      step();
      for (int i = 0; i < n; i++) begin
        set_exp(1, 0, 0, 0, 0, 1);
        step();
      end
      if (!tmo) begin
        if (rd) exp_rdata = ld_val(f3, a);
        else for (int i = 0; i < sz; i++) mdl_mem[int'(a[7:0]) + i] = wd[8*i +: 8];
      end
      set_exp(0, 0, 0, 1, tmo, 1);
      step();
    end
    i_lsu_wren = 1'b0; i_lsu_rden = 1'b0;
    set_exp(0, 0, 0, 0, 0, 0);
    step();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_stall"}, 32'(o_lsu_stall), 32'd0);
    chk({tag, "_wren"}, 32'(o_sram_wren), 32'd0);
    chk({tag, "_rden"}, 32'(o_sram_rden), 32'd0);
    chk({tag, "_done"}, 32'(o_lsu_done), 32'd0);
    chk({tag, "_err"}, 32'(o_lsu_err), 32'd0);
    chk({tag, "_rdata"}, o_lsu_rdata, 32'd0);
    chk({tag, "_addr"}, 32'(o_sram_addr), 32'd0);
    chk({tag, "_bmask"}, 32'(o_sram_bmask), 32'd0);
    chk({tag, "_wdata"}, o_sram_wdata, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) rsp_mem[i] = '0;
    for (int i = 0; i < 256; i++) mdl_mem[i] = '0;

    repeat (2) step();
    chk_all_zero("reset");
    i_reset = 1'b0;
    step();
    chk("idle_stall", 32'(o_lsu_stall), 32'd0);

    chk_en = 1'b1;
    // Store word, ack two cycles after the pulse.
    xact(1, 0, SW, 32'h10, 32'hDEADBEEF, 2);
    chk("sw_pulses", 32'(wr_pulses), 32'd1);
    chk("sw_addr", 32'(cap_addr), 32'h8);
    chk("sw_bmask", 32'(cap_bm), 32'hF);
    chk("sw_wdata", cap_wd, 32'hDEADBEEF);
    chk("sw_stall_cycles", 32'(stall_cnt), 32'd4);

    // Fill 0x14 and exercise every load flavour.
    xact(1, 0, SW, 32'h14, 32'h80FF7F01, 1);
    xact(0, 1, LB, 32'h17, 32'h0, 3);
    chk("lb_17", o_lsu_rdata, 32'hFFFFFF80);
    xact(0, 1, LBU, 32'h17, 32'h0, 1);
    chk("lbu_17", o_lsu_rdata, 32'h00000080);
    xact(0, 1, LH, 32'h16, 32'h0, 2);
    chk("lh_16", o_lsu_rdata, 32'hFFFF80FF);
    xact(0, 1, LHU, 32'h14, 32'h0, 1);
    chk("lhu_14", o_lsu_rdata, 32'h00007F01);
    xact(0, 1, LW, 32'h14, 32'h0, 4);
    chk("lw_14", o_lsu_rdata, 32'h80FF7F01);

    // Sub-word stores and the merged word they leave behind.
    xact(1, 0, SH, 32'h22, 32'h1234ABCD, 1);
    chk("sh_bmask", 32'(cap_bm), 32'hC);
    chk("sh_wdata", cap_wd, 32'hABCDABCD);
    xact(1, 0, SB, 32'h21, 32'h00000055, 2);
    chk("sb_bmask", 32'(cap_bm), 32'h2);
    chk("sb_wdata", cap_wd, 32'h55555555);
    xact(0, 1, LW, 32'h20, 32'h0, 1);
    chk("lw_20", o_lsu_rdata, 32'hABCD5500);

    // Illegal requests: error pulse, no SRAM access, load data untouched.
    xact(0, 1, LW, 32'h02, 32'h0, 1);
    chk("e_lw02_pulses", 32'(wr_pulses + rd_pulses), 32'd0);
    xact(1, 0, SH, 32'h01, 32'hFFFF, 1);
    chk("e_sh01_pulses", 32'(wr_pulses + rd_pulses), 32'd0);
    xact(1, 1, LW, 32'h14, 32'h0, 1);
    chk("e_both_pulses", 32'(wr_pulses + rd_pulses), 32'd0);
    xact(0, 1, LW, 32'h0008_0000, 32'h0, 1);
    chk("e_window_pulses", 32'(wr_pulses + rd_pulses), 32'd0);
    xact(0, 1, 3'd3, 32'h14, 32'h0, 1);
    xact(1, 0, 3'd4, 32'h14, 32'h0, 1);
    chk("e_rdata_kept", o_lsu_rdata, 32'hABCD5500);

    // No ack at all, then an ack on the very last WAIT cycle.
    xact(0, 1, LW, 32'h14, 32'h0, 0);
    chk("tmo_stall_cycles", 32'(stall_cnt), 32'd18);
    chk("tmo_rdata_kept", o_lsu_rdata, 32'hABCD5500);
    xact(0, 1, LHU, 32'h14, 32'h0, TO);
    chk("late_ack_rdata", o_lsu_rdata, 32'h00007F01);
    chk("late_ack_stall_cycles", 32'(stall_cnt), 32'd18);

    // Reset in the middle of WAIT with the request still held.
    chk_en = 1'b0;
    ack_dly = 0;
    i_lsu_rden = 1'b1; i_lsu_funct3 = LW; i_lsu_addr = 32'h14;
    repeat (3) step();
    chk("rst_mid_stall", 32'(o_lsu_stall), 32'd1);
    i_reset = 1'b1;
    step();
    chk_all_zero("rst_mid");
    step();
    chk("rst_hold_rden", 32'(o_sram_rden), 32'd0);
    chk("rst_hold_stall", 32'(o_lsu_stall), 32'd0);
    ack_dly = 1;
    i_reset = 1'b0;
    #1;
    chk("relaunch_stall", 32'(o_lsu_stall), 32'd1);
    chk("relaunch_no_early_rden", 32'(o_sram_rden), 32'd0);
    step();
    chk("relaunch_rden", 32'(o_sram_rden), 32'd1);
    step();
    chk("relaunch_wait_rden", 32'(o_sram_rden), 32'd0);
    step();
    chk("relaunch_done", 32'(o_lsu_done), 32'd1);
    chk("relaunch_err", 32'(o_lsu_err), 32'd0);
    chk("relaunch_rdata", o_lsu_rdata, 32'h80FF7F01);
    i_lsu_rden = 1'b0;
    step();
    chk("relaunch_idle_done", 32'(o_lsu_done), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/sram_lsu_master.md
SRAM_LSU_MASTER -- requirements
Module: sram_lsu_master

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0000_0000: byte base of the 512 KiB SRAM window.
REQ-002 Parameter TIMEOUT_CYCLES, default 16: maximum Wait-state cycles tolerated before a bus error.
REQ-003 i_clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 i_reset  in  1  synchronous, active-high reset.
REQ-005 i_lsu_addr  in  32  byte address from the core.
REQ-006 i_lsu_wdata  in  32  store data, right-aligned.
REQ-007 i_lsu_wren / i_lsu_rden  in  1 each  store or load request, held by the core while stalled.
REQ-008 i_lsu_funct3  in  3  RV32I size/sign code: LB/LH/LW/LBU/LHU or SB/SH/SW.
REQ-009 o_lsu_rdata  out  32  formatted load result.
REQ-010 o_lsu_stall  out  1  core hold request.
REQ-011 o_lsu_done  out  1  one-cycle completion pulse.
REQ-012 o_lsu_err  out  1  one-cycle error pulse, coincident with o_lsu_done.
REQ-013 o_sram_addr  out  18  halfword address to the controller: {window byte offset[18:2], 1'b0}.
REQ-014 o_sram_wdata  out  32  lane-positioned store data.
REQ-015 o_sram_bmask  out  4  byte enables; bit i selects byte lane i.
REQ-016 o_sram_wren / o_sram_rden  out  1 each  single-cycle request pulses.
REQ-017 i_sram_rdata  in  32  controller read word.
REQ-018 i_sram_ack  in  1  controller completion.

Function
REQ-019 The FSM SHALL have five states: IDLE, ISSUE, WAIT, DONE, ERR. New requests SHALL be accepted only in IDLE.
REQ-020 In IDLE, a request is legal when exactly one of wren/rden is set, funct3 is valid, the access is aligned, and the address lies in [BASE_ADDR, BASE_ADDR+0x7FFFF]. A legal request SHALL go to ISSUE and latch addr, bmask and wdata.
REQ-021 In IDLE, any other request with wren or rden set SHALL go to ERR. This covers both-set, invalid funct3, halfword offset[0]=1, word offset!=0, and out-of-window addresses. ERR SHALL issue no SRAM access.
REQ-022 ISSUE SHALL assert exactly one of o_sram_wren/o_sram_rden for exactly one cycle, then go to WAIT. Both SHALL be 0 in every other state.
REQ-023 WAIT SHALL count cycles from 0.
- Sampling i_sram_ack=1 goes to DONE.
- A count reaching TIMEOUT_CYCLES-1 without ack goes to ERR.
- Ack arriving in the same cycle as the timeout SHALL win.
REQ-024 DONE and ERR SHALL each last one cycle and then return to IDLE.
- o_lsu_done=1 in both states; o_lsu_err=1 only in ERR.
- Requests still present during DONE or ERR SHALL NOT relaunch.
REQ-025 o_lsu_stall SHALL be combinational:
- 1 in IDLE when a legal request is present;
- 1 in ISSUE and WAIT;
- 0 in IDLE without a legal request, and in DONE and ERR.
REQ-026 Store lane mapping, with off = addr[1:0]:
- SB: bmask = 1<<off, wdata = {4{wdata[7:0]}}.
- SH: bmask = off[1] ? 4'b1100 : 4'b0011, wdata = {2{wdata[15:0]}}.
- SW: bmask = 4'b1111, wdata unchanged.
REQ-027 Loads SHALL use bmask = 4'b1111.
REQ-028 Load formatting SHALL capture i_sram_rdata on the WAIT-to-DONE edge.
- LB/LBU extract byte off; LH/LHU extract half off[1].
- LB and LH sign-extend; LBU and LHU zero-extend.
REQ-029 o_lsu_rdata SHALL be registered and hold its value until the next successful load. Stores and errors SHALL leave it unchanged.
REQ-030 o_sram_addr/wdata/bmask SHALL be registered and stable from ISSUE through DONE.

Reset
REQ-031 With i_reset=1 at a clock edge, the FSM SHALL go to IDLE, the counter SHALL clear, and all registered outputs SHALL become 0, even mid-transaction.
REQ-032 No ERR or DONE pulse SHALL be generated by reset.

Structure
REQ-033 Package sram_lsu_pkg SHALL hold:
- the state enum;
- the funct3 constants (LB=000, LH=001, LW=010, LBU=100, LHU=101, SB=000, SH=001, SW=010);
- the window size constant 19'h7FFFF.
REQ-034 One combinational sub-module, lsu_data_align, SHALL implement the REQ-026/REQ-028 lane mapping and the alignment check. The FSM, counter and registers SHALL stay in sram_lsu_master.

Verification
REQ-035 SW 0x0000_0010 data 0xDEADBEEF with a stub responder acking 2 cycles after the pulse -> one wren pulse, addr=18'h8, bmask=1111, stall for 4 cycles, done in the 5th.
REQ-036 Memory word at 0x14 = 0x80FF_7F01:
- LB 0x17 -> 0xFFFFFF80.
- LBU 0x17 -> 0x00000080.
- LH 0x16 -> 0xFFFF80FF.
- LHU 0x14 -> 0x00007F01.
REQ-037 SH 0x22 data 0x1234ABCD -> bmask=1100, wdata=0xABCDABCD; SB 0x21 -> bmask=0010.
REQ-038 Each of these -> ERR pulse with no SRAM pulse and o_lsu_rdata unchanged:
- LW 0x02;
- SH 0x01;
- wren and rden together;
- address 0x0008_0000 with BASE_ADDR=0.
REQ-039 Responder never acks -> err and done after TIMEOUT_CYCLES WAIT cycles. Ack arriving exactly on cycle 15 -> normal DONE.
REQ-040 Reset asserted in WAIT -> next cycle IDLE, all outputs 0. A held request relaunches only after reset deasserts.
